// File: rtl/barrel_pkg.sv
// Shared op-code definitions for the barrel_pipe shifter/rotator.
package barrel_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ROL = 3'b000;
  localparam op_t OP_ROR = 3'b001;
  localparam op_t OP_SLL = 3'b010;
  localparam op_t OP_SRL = 3'b011;
  localparam op_t OP_SRA = 3'b100;

endpackage

// File: rtl/barrel_stage.sv
// One barrel_pipe stage: registers an operation, then displaces it by 2^STAGE.
// With BARREL_PIPE_ARITH_EN a sign bit travels alongside and fills SRA vacancies.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 0,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  op_t              op_i,
  input  logic [SHW-1:0]   amt_i,
`ifdef BARREL_PIPE_ARITH_EN
  input  logic             sign_i,
  output logic             sign_o,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output op_t              op_o,
  output logic [SHW-1:0]   amt_o
);

  localparam int DISP = 1 << STAGE;
  localparam logic [WIDTH-1:0] HI_MASK = ~({WIDTH{1'b1}} >> DISP);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  op_t              op_d, op_q;
  logic [SHW-1:0]   amt_d, amt_q;
  logic [WIDTH-1:0] shifted;
`ifdef BARREL_PIPE_ARITH_EN
  logic             sign_d, sign_q;
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
    amt_d   = amt_q;
    if (en) begin
      valid_d = valid_i;
      data_d  = data_i;
      op_d    = op_i;
      amt_d   = amt_i;
    end
  end

`ifdef BARREL_PIPE_ARITH_EN
  always_comb begin
    sign_d = sign_q;
    if (en) sign_d = sign_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end

  assign sign_o = sign_q;
`endif

  // Everything, including data, clears so an idle pipe presents zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= OP_ROL;
      amt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
    end
  end

  always_comb begin
    shifted = data_q;
    if (amt_q[STAGE]) begin
      case (op_q)
        OP_ROL:  shifted = (data_q << DISP) | (data_q >> (WIDTH - DISP));
        OP_ROR:  shifted = (data_q >> DISP) | (data_q << (WIDTH - DISP));
        OP_SLL:  shifted = data_q << DISP;
        OP_SRL:  shifted = data_q >> DISP;
`ifdef BARREL_PIPE_ARITH_EN
        OP_SRA:  shifted = (data_q >> DISP) | (sign_q ? HI_MASK : '0);
`else
        OP_SRA:  shifted = data_q >> DISP;
`endif
        default: shifted = data_q;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign data_o  = shifted;
  assign op_o    = op_q;
  assign amt_o   = amt_q;

endmodule

// File: rtl/barrel_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides.
// Define BARREL_PIPE_ARITH_EN to make op 100 an arithmetic right shift.
module barrel_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic             adv;
  logic [SHW:0]     vld;
  logic [WIDTH-1:0] dat   [SHW+1];
  op_t              op_s  [SHW+1];
  logic [SHW-1:0]   amt_s [SHW+1];
`ifdef BARREL_PIPE_ARITH_EN
  logic [SHW:0]     sgn;
`endif

  logic             out_vld_d, out_vld_q;
  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic             unused_tail;

  // One global enable: the whole pipe moves unless a result is stuck at the output.
  assign adv      = out_ready | ~out_vld_q;
  assign in_ready = adv;

  assign vld[0]   = in_valid & adv;
  assign dat[0]   = in_data;
  assign op_s[0]  = op_t'(in_op);
  assign amt_s[0] = in_amt;
`ifdef BARREL_PIPE_ARITH_EN
  assign sgn[0]   = in_data[WIDTH-1];
`endif

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      barrel_stage #(
        .WIDTH (WIDTH),
        .STAGE (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (adv),
        .valid_i (vld[k]),
        .data_i  (dat[k]),
        .op_i    (op_s[k]),
        .amt_i   (amt_s[k]),
`ifdef BARREL_PIPE_ARITH_EN
        .sign_i  (sgn[k]),
        .sign_o  (sgn[k+1]),
`endif
        .valid_o (vld[k+1]),
        .data_o  (dat[k+1]),
        .op_o    (op_s[k+1]),
        .amt_o   (amt_s[k+1])
      );
    end
  endgenerate

`ifdef BARREL_PIPE_ARITH_EN
  assign unused_tail = ^{op_s[SHW], amt_s[SHW], sgn[SHW]};
`else
  assign unused_tail = ^{op_s[SHW], amt_s[SHW]};
`endif

  // Output register captures the last stage's displaced word.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (adv) begin
      out_vld_d  = vld[SHW];
      out_data_d = dat[SHW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_zero  = ~|out_data_q;

endmodule

// File: tb/tb_barrel_pipe.sv
// Self-checking bench for barrel_pipe (WIDTH = 8) with an in-bench reference model.
module tb_barrel_pipe;
  import barrel_pkg::*;

  localparam int W  = 8;
  localparam int SH = 3;
`ifdef BARREL_PIPE_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SH-1:0] in_amt;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;

  int nchk = 0;
  int nerr = 0;
  int npop = 0;
  int cyc  = 0;
  logic [W-1:0] exp_q[$];
  int pop_cyc[$];
  bit rnd_done;

  barrel_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Bit-level definition: each result bit names the operand bit it comes from.
  function automatic logic [W-1:0] ref_op(input op_t op, input logic [W-1:0] x, input int a);
    logic [W-1:0] r;
    logic fill;
    int src;
    fill = (op == OP_SRA && ARITH) ? x[W-1] : 1'b0;
    for (int i = 0; i < W; i++) begin
      case (op)
        OP_ROL:         src = (i - a + W) % W;
        OP_ROR:         src = (i + a) % W;
        OP_SLL:         src = i - a;
        OP_SRL, OP_SRA: src = i + a;
        default:        src = i;
      endcase
      r[i] = (src >= 0 && src < W) ? x[src] : fill;
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the acceptance edge.
  task automatic send(input op_t op, input logic [W-1:0] d, input logic [SH-1:0] a, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        check("send_timeout", 64'(waited), 64'(0));
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(ref_op(op, d, int'(a)));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waited);
    send(op_t'($urandom_range(0, 7)), W'($urandom), SH'($urandom_range(0, 7)), waited);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Single op into an empty pipe: result must appear exactly SH edges after acceptance.
  task automatic directed(input string name, input op_t op, input logic [W-1:0] d,
                          input logic [SH-1:0] a, input logic [W-1:0] expv);
    int w;
    send(op, d, a, w);
    for (int k = 1; k <= SH; k++) begin
      @(posedge clk);
      #1;
      if (k < SH) begin
        check({name, "_early_valid"}, 64'(out_valid), 64'(0));
      end else begin
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_data"}, 64'(out_data), 64'(expv));
        check({name, "_zero"}, 64'(out_zero), 64'(expv == '0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Compare process: every output transfer against the model, plus hold stability.
  initial begin
    logic hold;
    logic [W-1:0] held;
    logic [W-1:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_data", 64'(out_data), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_result: got 0x%0h, expected no result", out_data);
          end else begin
            e = exp_q.pop_front();
            check("stream_data", 64'(out_data), 64'(e));
            check("stream_zero", 64'(out_zero), 64'(e == '0));
            npop++;
            pop_cyc.push_back(cyc);
          end
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end
    end
  end

  initial begin
    int w;
    int p0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_zero", 64'(out_zero), 64'(1));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    directed("rol", OP_ROL, 8'h96, 3'd3, 8'hB4);
    directed("ror", OP_ROR, 8'h96, 3'd3, 8'hD2);
    directed("sra", OP_SRA, 8'h96, 3'd2, ARITH ? 8'hE5 : 8'h25);
    directed("srl", OP_SRL, 8'h96, 3'd2, 8'h25);
    directed("sll7", OP_SLL, 8'h96, 3'd7, 8'h00);
    directed("sll0", OP_SLL, 8'h96, 3'd0, 8'h96);
    directed("pass", op_t'(3'b111), 8'h5A, 3'd5, 8'h5A);

    // Back-to-back stream: one acceptance and one result per cycle.
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      send_rand(w);
      check("b2b_accept_wait", 64'(w), 64'(0));
    end
    wait_drain("b2b");
    check("b2b_count", 64'(pop_cyc.size()), 64'(16));
    if (pop_cyc.size() == 16) begin
      for (int i = 1; i < 16; i++)
        check("b2b_spacing", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));
    end

    // Output stalled for 5 cycles once results start flowing.
    p0 = npop;
    fork
      begin
        int ws;
        for (int i = 0; i < 12; i++) send_rand(ws);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("stall_fill_timeout", 64'(n < 100), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("stall");
    check("stall_count", 64'(npop - p0), 64'(12));

    // Random stream with random backpressure.
    p0 = npop;
    fork
      begin
        int wr;
        for (int i = 0; i < 40; i++) send_rand(wr);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("rand");
    check("rand_count", 64'(npop - p0), 64'(40));

    // Reset asserted with three ops in flight.
    p0 = npop;
    for (int i = 0; i < 3; i++) send_rand(w);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_data", 64'(out_data), 64'(0));
    check("midrst_out_zero", 64'(out_zero), 64'(1));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_no_early", 64'(npop - p0), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_hold_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    directed("post_rst_rol", OP_ROL, 8'h01, 3'd1, 8'h02);
    repeat (4) @(posedge clk);
    #1;
    check("final_queue", 64'(exp_q.size()), 64'(0));
    check("final_idle", 64'(out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/barrel_pipe.md
# barrel_pipe

Parametrised, pipelined barrel shifter/rotator with valid/ready handshake on both sides. It supports rotate left/right, logical shift left/right and optional arithmetic shift right. The word width is a power of two, and throughput is one operation per cycle. It sits between operand-producing logic and downstream datapath consumers, and supersedes fixed 8-bit combinational rotators.

## Interface
Parameters:
- WIDTH, 8, data width; power of two, 2..64
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SHW  shift/rotate amount, 0..WIDTH-1
- in_op  in  3  operation code (see Operation)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_zero  out  1  result equals zero

## Operation
- Op codes:
  - 000 ROL: rotate left
  - 001 ROR: rotate right
  - 010 SLL: logical shift left, zero fill
  - 011 SRL: logical shift right, zero fill
  - 100 SRA: arithmetic shift right, sign fill (see Configuration)
  - 101..111: pass-through, out_data = in_data
- in_amt = 0 gives a pass-through result for every op.
- Amounts are never out of range; the full in_amt range is legal.
- Pipeline of SHW stages. Stage k applies a displacement of 2^k when in_amt[k] = 1 and passes the word through otherwise.
- Each stage registers data, op, remaining amount bits and a valid bit.
- Rotates wrap bits end-around. Shifts discard bits moved out of the word. Fill is zero, or the original MSB for SRA.
- out_zero is the combinational NOR of out_data. It is meaningful only while out_valid = 1.
- Handshake:
  - Transfer on the input side when in_valid & in_ready.
  - Transfer on the output side when out_valid & out_ready.
- Global advance enable: adv = out_ready | ~out_valid. in_ready = adv.
- When adv = 1, every stage register loads from its predecessor. Stage 0 loads in_valid & in_ready together with the input fields.
- When adv = 0, all stages hold. No data is lost or reordered.
- Bubbles (invalid stages) are not collapsed. They travel through the pipe and still advance under adv.
- Results emerge in acceptance order.
- out_data and out_valid stay stable while out_valid = 1 and out_ready = 0.

## Timing
- Latency: an operation accepted on edge N is presented on out_valid/out_data after edge N+SHW.
  - WIDTH = 8: 3 cycles.
- Throughput: 1 operation per cycle while out_ready = 1.
- Reset (asserted asynchronously, at any time including mid-stream): all stage valid bits clear immediately.
  - out_valid = 0, out_data = 0, out_zero = 1 (data is 0), in_ready = 1.
  - In-flight operations are discarded.
- Reset release is synchronous to clk. The first acceptance is possible on the first rising edge after release.
- Simultaneous output acceptance and input acceptance in the same cycle is legal and required for full throughput.
- in_ready depends combinationally on out_ready. There is no combinational path from in_* to out_*.

## Configuration
- Macro: BARREL_PIPE_ARITH_EN.
- Defined: op 100 performs SRA; vacated MSBs take the original operand MSB at every stage. The stage pipeline carries a sign bit.
- Undefined: op 100 behaves as SRL (zero fill); no sign bit register exists.
- All other ops are identical in both builds.

## Structure
- Package barrel_pkg holds:
  - op-code localparams: OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA
  - a width-3 op typedef
- Sub-module barrel_stage:
  - parameters WIDTH and STAGE index
  - combinational displacement of 2^STAGE selected by its amount bit and op, plus the stage register with valid and enable
- barrel_pipe instantiates SHW barrel_stage instances in a generate loop and holds the handshake logic.

## Test plan
All scenarios use WIDTH = 8.
- ROL 0x96 amt 3 -> out_data 0xB4 after 3 cycles. ROR 0x96 amt 3 -> 0xD2.
- Op 100 on 0x96 amt 2 -> 0xE5 with BARREL_PIPE_ARITH_EN, 0x25 without. SRL 0x96 amt 2 -> 0x25 in both builds.
- SLL 0x96 amt 7 -> 0x00 with out_zero = 1. SLL 0x96 amt 0 -> 0x96. Op 111 on 0x5A amt 5 -> 0x5A.
- Back-to-back stream of 16 random ops with out_ready = 1 -> one result per cycle, each matching a reference model, in order.
- Stream with out_ready = 0 for 5 cycles after the pipe fills -> in_ready = 0 within those cycles, out_data held stable. After release the stream resumes with no loss or duplication.
- Assert rst_n low mid-stream with 3 ops in flight -> out_valid = 0 and out_data = 0 immediately. After release, a new op ROL 0x01 amt 1 yields 0x02 with latency 3.
